tff_bank: RTL and testbench
===========================

// Module: tff_bank
// PURPOSE
//   Parametrised bank of WIDTH T flip-flops with a common clock and asynchronous reset.
//   Two modes:
//   - independent: each bit toggles on its own T input.
//   - chained: the bits form a synchronous binary counter, with bit i toggling on the carry of bits 0..i-1.
//   Adds global enable, synchronous clear, parallel load, terminal-count and per-bit toggle-event outputs.
//   Used for divider chains, event counters and toggle-flag registers.
// PARAMETERS
//   WIDTH      8   number of flip-flops / counter bits, >=1
//   RESET_VAL  0   WIDTH-bit value applied to Q on rst
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   en        in   1      global toggle enable; load/clear ignore it
//   mode      in   1      0 = independent toggle, 1 = chained counter
//   T         in   WIDTH  toggle requests; in chained mode only T[0] is used (count enable)
//   sync_clr  in   1      synchronous clear of Q to 0
//   load      in   1      synchronous parallel load
//   load_val  in   WIDTH  value for load
//   dn        in   1      count direction, 1 = down (present only with TFF_BANK_DIR_EN)
//   Q         out  WIDTH  flip-flop state
//   toggled   out  WIDTH  registered: bit i toggled via the toggle path in the previous cycle
//   tc        out  1      combinational terminal count / carry out (chained mode only)
// BEHAVIOUR
//   - Reset: rst high -> Q = RESET_VAL and toggled = 0, immediately and independent of clk. Held while rst is high.
//   - Per-edge priority: rst > sync_clr > load > toggle > hold.
//   - sync_clr: Q <= 0 and toggled <= 0.
//   - load: Q <= load_val and toggled <= 0.
//   - Toggle vector tv. If en == 0, tv = 0.
//     - mode 0: tv = T.
//     - mode 1: tv[0] = T[0]; tv[i] = T[0] & (&Q[i-1:0]).
//   - Toggle update: Q <= Q ^ tv and toggled <= tv. Bits with tv = 0 hold.
//   - Latency: one clk edge from input to Q. toggled lags Q by zero edges; it updates on the same edge as Q.
//   - tc = mode & en & T[0] & (&Q) when counting up. Not registered.
//     - tc is 0 when mode = 0, or when sync_clr or load is asserted.
//   - Wrap-around: chained mode at Q = all-ones with a count -> Q = 0, toggled = all-ones, tc = 1 in the cycle before.
//   - Mode change: takes effect on the next edge. No state is cleared.
//   - WIDTH = 1: chained mode is identical to independent mode; tc = en & T[0] & Q[0].
//   - Reset mid-count: Q goes to RESET_VAL asynchronously. Counting resumes from RESET_VAL on the first edge after rst deasserts.
// CONFIGURATION
//   TFF_BANK_DIR_EN defined:
//   - Port dn exists.
//   - Chained mode with dn = 1: tv[i] = T[0] & (~|Q[i-1:0]); tc = mode & en & T[0] & (Q == 0).
//   - Down-count wrap: 0 -> all-ones.
//   - mode 0 ignores dn.
//   TFF_BANK_DIR_EN undefined:
//   - No dn port.
//   - Up-count only, as described above.
// TESTING (WIDTH=4, RESET_VAL=4'h5)
//   1. rst pulse between edges -> Q = 5 and toggled = 0 immediately; T = F, en = 1 held through rst -> Q stays 5.
//   2. mode 0, en = 1, T = 4'b1010 for 2 edges from Q = 5 -> Q = F, then 5; toggled = 1010 both cycles.
//      en = 0 -> Q holds and toggled = 0.
//   3. mode 1, T[0] = 1, en = 1 from Q = 0 for 16 edges -> Q counts 0..F..0.
//      tc = 1 only while Q = F; toggled = F after the wrap.
//   4. load = 1 with load_val = C and sync_clr = 1 in the same cycle -> Q = 0.
//      Next cycle load alone -> Q = C, toggled = 0, tc = 0.
//   5. mode 1 counting, mode -> 0 with T = 4'b0001 at Q = 7 -> Q = 6 (not 8).
//   6. TFF_BANK_DIR_EN: dn = 1 from Q = 1 -> 0 then F; tc = 1 while Q = 0.
//      Build without the macro -> port absent; test 3 passes.

Source files
------------

// File: rtl/tff_bank_if.sv
// Control/status bundle for tff_bank. TFF_BANK_DIR_EN adds the dn (count-down) signal.
interface tff_bank_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] T;
  logic             sync_clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
`ifdef TFF_BANK_DIR_EN
  logic             dn;
`endif
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] toggled;
  logic             tc;

`ifdef TFF_BANK_DIR_EN
  modport master (output en, mode, T, sync_clr, load, load_val, dn,
                  input  Q, toggled, tc);
  modport slave  (input  en, mode, T, sync_clr, load, load_val, dn,
                  output Q, toggled, tc);
`else
  modport master (output en, mode, T, sync_clr, load, load_val,
                  input  Q, toggled, tc);
  modport slave  (input  en, mode, T, sync_clr, load, load_val,
                  output Q, toggled, tc);
`endif
endinterface

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops: independent toggles or a chained binary counter.
// TFF_BANK_DIR_EN enables down counting in chained mode via bus.dn.
module tff_bank #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  tff_bank_if.slave  bus
);
  localparam int unsigned W = WIDTH;

  logic [W-1:0] q_r;
  logic [W-1:0] tog_r;
  logic [W-1:0] cmp_c;
  logic [W-1:0] run_c;
  logic [W-1:0] tv_c;
  logic         dn_c;
  logic         tc_c;

`ifdef TFF_BANK_DIR_EN
  assign dn_c = bus.dn;
`else
  assign dn_c = 1'b0;
`endif

  // Bits that must all be "saturated" (1 up, 0 down) for the carry/borrow to reach bit i.
  assign cmp_c    = dn_c ? ~q_r : q_r;
  assign run_c[0] = 1'b1;
  for (genvar i = 1; i < W; i++) begin : g_run
    assign run_c[i] = &cmp_c[i-1:0];
  end

  always_comb begin
    tv_c = '0;
    if (bus.en) begin
      if (bus.mode) tv_c = {W{bus.T[0]}} & run_c;
      else          tv_c = bus.T;
    end
  end

  // Terminal count is suppressed whenever clear or load overrides the toggle path.
  assign tc_c = bus.mode & bus.en & bus.T[0] & (&cmp_c) & ~bus.sync_clr & ~bus.load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= RESET_VAL;
      tog_r <= '0;
    end else if (bus.sync_clr) begin
      q_r   <= '0;
      tog_r <= '0;
    end else if (bus.load) begin
      q_r   <= bus.load_val;
      tog_r <= '0;
    end else begin
      q_r   <= q_r ^ tv_c;
      tog_r <= tv_c;
    end
  end

  assign bus.Q       = q_r;
  assign bus.toggled = tog_r;
  assign bus.tc      = tc_c;
endmodule

// File: tb/tb_tff_bank.sv
// Self-checking bench for tff_bank (WIDTH=4, RESET_VAL=5): vector table, counting loop, corner sequences.
module tb_tff_bank;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  tff_bank_if #(.WIDTH(4)) bus ();

  tff_bank #(.WIDTH(4), .RESET_VAL(4'h5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en;
    logic       mode;
    logic [3:0] t;
    logic       clr;
    logic       ld;
    logic [3:0] lv;
    logic       xtc;
    logic [3:0] xq;
    logic [3:0] xtog;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic [3:0] tog;
  } exp_t;

  localparam int NV = 17;
  vec_t tbl [NV];
  exp_t sb  [$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, check tc before the edge, queue Q/toggled expectations for after it.
  task automatic step(input string name, input logic e, input logic m, input logic [3:0] t,
                      input logic c, input logic l, input logic [3:0] lv,
                      input logic xtc, input logic [3:0] xq, input logic [3:0] xtog);
    exp_t it;
    exp_t got;
    bus.en = e; bus.mode = m; bus.T = t; bus.sync_clr = c; bus.load = l; bus.load_val = lv;
    #1;
    chk({name, " tc"}, {3'b000, bus.tc}, {3'b000, xtc});
    it.name = name; it.q = xq; it.tog = xtog;
    sb.push_back(it);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.name, " Q"}, bus.Q, got.q);
    chk({got.name, " toggled"}, bus.toggled, got.tog);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //          name          en mode t     clr ld lv    tc q     tog
    tbl[0]  = '{"ind_a",      1, 0, 4'hA, 0, 0, 4'h0, 0, 4'hF, 4'hA};
    tbl[1]  = '{"ind_b",      1, 0, 4'hA, 0, 0, 4'h0, 0, 4'h5, 4'hA};
    tbl[2]  = '{"en_low",     0, 0, 4'hA, 0, 0, 4'h0, 0, 4'h5, 4'h0};
    tbl[3]  = '{"chn_t0only", 1, 1, 4'hF, 0, 0, 4'h0, 0, 4'h6, 4'h3};
    tbl[4]  = '{"chn_t0low",  1, 1, 4'hE, 0, 0, 4'h0, 0, 4'h6, 4'h0};
    tbl[5]  = '{"ld_f",       1, 1, 4'h1, 0, 1, 4'hF, 0, 4'hF, 4'h0};
    tbl[6]  = '{"ld_gate_tc", 1, 1, 4'h1, 0, 1, 4'hC, 0, 4'hC, 4'h0};
    tbl[7]  = '{"ld_f2",      1, 1, 4'h1, 0, 1, 4'hF, 0, 4'hF, 4'h0};
    tbl[8]  = '{"clr_ld",     1, 1, 4'h1, 1, 1, 4'hC, 0, 4'h0, 4'h0};
    tbl[9]  = '{"ld_alone",   0, 0, 4'h0, 0, 1, 4'hC, 0, 4'hC, 4'h0};
    tbl[10] = '{"ld_6",       0, 0, 4'h0, 0, 1, 4'h6, 0, 4'h6, 4'h0};
    tbl[11] = '{"chn_67",     1, 1, 4'h1, 0, 0, 4'h0, 0, 4'h7, 4'h1};
    tbl[12] = '{"mode_sw",    1, 0, 4'h1, 0, 0, 4'h0, 0, 4'h6, 4'h1};
    tbl[13] = '{"chn_67b",    1, 1, 4'h1, 0, 0, 4'h0, 0, 4'h7, 4'h1};
    tbl[14] = '{"chn_78",     1, 1, 4'h1, 0, 0, 4'h0, 0, 4'h8, 4'hF};
    tbl[15] = '{"chn_en_off", 0, 1, 4'h1, 0, 0, 4'h0, 0, 4'h8, 4'h0};
    tbl[16] = '{"clr",        0, 0, 4'h0, 1, 0, 4'h0, 0, 4'h0, 4'h0};

    // Reset held across edges with toggling requested.
    rst = 1'b1;
    bus.en = 1'b1; bus.mode = 1'b0; bus.T = 4'hF;
    bus.sync_clr = 1'b0; bus.load = 1'b0; bus.load_val = 4'h0;
`ifdef TFF_BANK_DIR_EN
    bus.dn = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold Q", bus.Q, 4'h5);
    chk("rst_hold toggled", bus.toggled, 4'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++)
      step(tbl[i].name, tbl[i].en, tbl[i].mode, tbl[i].t, tbl[i].clr, tbl[i].ld,
           tbl[i].lv, tbl[i].xtc, tbl[i].xq, tbl[i].xtog);

    // Full up-count with wrap; tc only while Q is all-ones.
    for (int k = 0; k < 16; k++)
      step($sformatf("cnt%0d", k), 1, 1, 4'h1, 0, 0, 4'h0, (k == 15),
           4'(k + 1), 4'(k) ^ 4'(k + 1));

    step("ld_ff",      0, 0, 4'h0, 0, 1, 4'hF, 0, 4'hF, 4'h0);
    step("tc_en0",     0, 1, 4'h1, 0, 0, 4'h0, 0, 4'hF, 4'h0);
    step("tc_mode0",   1, 0, 4'h1, 0, 0, 4'h0, 0, 4'hE, 4'h1);
    step("clr_gate",   1, 0, 4'h1, 0, 1, 4'hF, 0, 4'hF, 4'h0);
    step("clr_tc",     1, 1, 4'h1, 1, 0, 4'h0, 0, 4'h0, 4'h0);

    // Asynchronous reset mid-count, then resume from RESET_VAL.
    step("ld_3",       0, 0, 4'h0, 0, 1, 4'h3, 0, 4'h3, 4'h0);
    step("cnt_34",     1, 1, 4'h1, 0, 0, 4'h0, 0, 4'h4, 4'h7);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst Q", bus.Q, 4'h5);
    chk("async_rst toggled", bus.toggled, 4'h0);
    @(posedge clk);
    #1;
    chk("rst_edge Q", bus.Q, 4'h5);
    rst = 1'b0;
    step("resume",     1, 1, 4'h1, 0, 0, 4'h0, 0, 4'h6, 4'h3);

`ifdef TFF_BANK_DIR_EN
    step("ld_1",       0, 0, 4'h0, 0, 1, 4'h1, 0, 4'h1, 4'h0);
    bus.dn = 1'b1;
    step("dn_10",      1, 1, 4'h1, 0, 0, 4'h0, 0, 4'h0, 4'h1);
    step("dn_wrap",    1, 1, 4'h1, 0, 0, 4'h0, 1, 4'hF, 4'hF);
    step("dn_fe",      1, 1, 4'h1, 0, 0, 4'h0, 0, 4'hE, 4'h1);
    step("dn_mode0",   1, 0, 4'h1, 0, 0, 4'h0, 0, 4'hF, 4'h1);
    bus.dn = 1'b0;
`endif

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
